// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debounce front end.
// State encoding is fixed so the debounced level is simply state[1].
package debounce_pkg;

    typedef enum logic [1:0] {
        LOW       = 2'b00,
        WAIT_HIGH = 2'b01,
        HIGH      = 2'b10,
        WAIT_LOW  = 2'b11
    } state_e;

    localparam int DEBOUNCE_CYCLES_SIM   = 4;
    localparam int DEBOUNCE_CYCLES_BOARD = 500000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input.
// Reusable for any async control input (buttons, switches).
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic sync1_q;
    logic sync2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= RESET_VAL;
            sync2_q <= RESET_VAL;
        end else begin
            sync1_q <= d;
            sync2_q <= sync1_q;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/button_debouncer.sv
// Push-button front end: polarity fix, 2-flop sync, and a qualification FSM
// that only moves the level after DEBOUNCE_CYCLES+1 consecutive stable samples.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES  = DEBOUNCE_CYCLES_BOARD,
    parameter int CNT_WIDTH        = 19,
    parameter bit INPUT_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       button_raw,
    output logic       level,
    output logic [1:0] state
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 btn;
    logic                 sync2;
    state_e               state_q;
    state_e               state_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    assign btn = button_raw ^ INPUT_ACTIVE_LOW;

    sync_2ff #(
        .RESET_VAL(1'b0)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn),
        .q    (sync2)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= LOW;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // A reversal on the terminal-count cycle wins: the bounce check precedes the commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOW: begin
                if (sync2) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = '0;
                end
            end
            WAIT_HIGH: begin
                if (!sync2) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HIGH: begin
                if (!sync2) begin
                    state_d = WAIT_LOW;
                    cnt_d   = '0;
                end
            end
            WAIT_LOW: begin
                if (sync2) begin
                    state_d = HIGH;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = LOW;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = LOW;
                cnt_d   = '0;
            end
        endcase
    end

    assign state = state_q;
    assign level = state_q[1];

endmodule
